// File: rtl/dmem_resp.sv
// dmem_resp: services core load/store requests on a 32-bit synchronous data memory.
// Define DMEM_ALIGN_CHK_EN to flag misaligned accesses; otherwise addresses are aligned down.
module dmem_resp #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ,
    input  logic        DMEM_RW,
    input  logic [1:0]  SIZE,
    input  logic        UNS,
    input  logic [63:0] ADDR,
    input  logic [63:0] WDATA,
    output logic [63:0] RDATA,
    output logic        DONE,
    output logic        ERR,
    output logic        BUSY,
    output logic [31:0] MEM_ADDR,
    output logic        MEM_WR,
    output logic [31:0] MEM_DIN,
    input  logic [31:0] MEM_DOUT
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD_LO = 3'd1;
    localparam logic [2:0] RD_HI = 3'd2;
    localparam logic [2:0] WR_LO = 3'd3;
    localparam logic [2:0] WR_HI = 3'd4;
    localparam logic [2:0] RESP  = 3'd5;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rw_q, rw_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [31:0]      addr_q, addr_d;
    logic [63:0]      wdata_q, wdata_d;
    logic [31:0]      lo_q, lo_d;
    logic [63:0]      rdata_q, rdata_d;

    logic        misaligned;
    logic [31:0] req_addr;
    logic [31:0] lo_addr;
    logic [31:0] hi_addr;
    logic [31:0] merged;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^ADDR[63:32];

    // Sub-word sign/zero extraction from one memory word
    function automatic logic [63:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] a, input logic u);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (sz)
            SZ_B:    load_ext = u ? {56'd0, b} : {{56{b[7]}}, b};
            SZ_H:    load_ext = u ? {48'd0, h} : {{48{h[15]}}, h};
            default: load_ext = u ? {32'd0, w} : {{32{w[31]}}, w};
        endcase
    endfunction

`ifdef DMEM_ALIGN_CHK_EN
    logic err_q, err_d;

    always_comb begin
        misaligned = 1'b0;
        case (SIZE)
            SZ_H:    misaligned = ADDR[0];
            SZ_W:    misaligned = |ADDR[1:0];
            SZ_D:    misaligned = |ADDR[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign req_addr = ADDR[31:0];
    assign ERR      = (state_q == RESP) & err_q;
`else
    assign misaligned = 1'b0;

    // Without the check, the access silently proceeds on the aligned-down address
    always_comb begin
        req_addr = ADDR[31:0];
        case (SIZE)
            SZ_H:    req_addr[0]   = 1'b0;
            SZ_W:    req_addr[1:0] = 2'b00;
            SZ_D:    req_addr[2:0] = 3'b000;
            default: req_addr      = ADDR[31:0];
        endcase
    end

    assign ERR = 1'b0;
`endif

    assign lo_addr = {addr_q[31:2], 2'b00};
    assign hi_addr = lo_addr + 32'd4;

    // Read-modify-write lane merge for byte/half stores
    always_comb begin
        merged = lo_q;
        if (size_q == SZ_B) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
`ifdef DMEM_ALIGN_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
`ifdef DMEM_ALIGN_CHK_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lo_d    = lo_q;
        rdata_d = rdata_q;
`ifdef DMEM_ALIGN_CHK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (REQ) begin
                    rw_d    = DMEM_RW;
                    size_d  = SIZE;
                    uns_d   = UNS;
                    addr_d  = req_addr;
                    wdata_d = WDATA;
                    cnt_d   = '0;
`ifdef DMEM_ALIGN_CHK_EN
                    err_d   = misaligned;
`endif
                    if (misaligned) begin
                        state_d = RESP;
                    end else if (DMEM_RW && SIZE[1]) begin
                        state_d = WR_LO;
                    end else begin
                        state_d = RD_LO;
                    end
                end
            end
            RD_LO: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    lo_d  = MEM_DOUT;
                    if (rw_q) begin
                        state_d = WR_LO;
                    end else if (size_q == SZ_D) begin
                        state_d = RD_HI;
                    end else begin
                        rdata_d = load_ext(MEM_DOUT, size_q, addr_q[1:0], uns_q);
                        state_d = RESP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_HI: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    rdata_d = {MEM_DOUT, lo_q};
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WR_LO:   state_d = (size_q == SZ_D) ? WR_HI : RESP;
            WR_HI:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory port decode; idle drives all zeros
    always_comb begin
        MEM_ADDR = '0;
        MEM_WR   = 1'b0;
        MEM_DIN  = '0;
        case (state_q)
            RD_LO: MEM_ADDR = lo_addr;
            RD_HI: MEM_ADDR = hi_addr;
            WR_LO: begin
                MEM_ADDR = lo_addr;
                MEM_WR   = 1'b1;
                MEM_DIN  = size_q[1] ? wdata_q[31:0] : merged;
            end
            WR_HI: begin
                MEM_ADDR = hi_addr;
                MEM_WR   = 1'b1;
                MEM_DIN  = wdata_q[63:32];
            end
            default: MEM_ADDR = '0;
        endcase
    end

    assign RDATA = rdata_q;
    assign DONE  = (state_q == RESP);
    assign BUSY  = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: directed bench for dmem_resp with a response scoreboard and a small
// one-cycle-latency memory model.
module tb_dmem_resp;

    localparam int unsigned LAT = 1;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        REQ = 1'b0;
    logic        DMEM_RW = 1'b0;
    logic [1:0]  SIZE = 2'b00;
    logic        UNS = 1'b0;
    logic [63:0] ADDR = '0;
    logic [63:0] WDATA = '0;
    logic [63:0] RDATA;
    logic        DONE;
    logic        ERR;
    logic        BUSY;
    logic [31:0] MEM_ADDR;
    logic        MEM_WR;
    logic [31:0] MEM_DIN;
    logic [31:0] MEM_DOUT;

    dmem_resp #(.RD_LAT(LAT)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .DMEM_RW(DMEM_RW), .SIZE(SIZE), .UNS(UNS),
        .ADDR(ADDR), .WDATA(WDATA), .RDATA(RDATA), .DONE(DONE), .ERR(ERR), .BUSY(BUSY),
        .MEM_ADDR(MEM_ADDR), .MEM_WR(MEM_WR), .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int wr_cnt = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Word-addressed memory, 1-cycle read latency
    logic [31:0] mem [0:1023];
    logic [31:0] dout = '0;
    logic        init_mem = 1'b1;

    always @(posedge CLK) begin
        if (init_mem) begin
            mem[10'h040] <= 32'h80FF7F01;
            mem[10'h0C0] <= 32'hAABBCCDD;
            mem[10'h100] <= 32'hCAFEBABE;
        end else if (MEM_WR) begin
            mem[MEM_ADDR[11:2]] <= MEM_DIN;
        end
        dout <= mem[MEM_ADDR[11:2]];
    end
    assign MEM_DOUT = dout;

    always @(negedge CLK) if (MEM_WR) wr_cnt <= wr_cnt + 1;

    logic [63:0] q_rd[$];
    logic        q_err[$];
    int          q_cyc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] rd, input logic err, input int done_cyc);
        q_rd.push_back(rd);
        q_err.push_back(err);
        q_cyc.push_back(done_cyc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q_cyc.size() != 0 && n < 30) begin
            @(negedge CLK);
            n++;
        end
        if (q_cyc.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", q_cyc.size());
            q_rd.delete();
            q_err.delete();
            q_cyc.delete();
        end
    endtask

    task automatic wait_idle();
        int n;
        @(negedge CLK);
        n = 0;
        while (BUSY && n < 20) begin
            @(negedge CLK);
            n++;
        end
    endtask

    // Issue one request, scramble inputs after acceptance, then wait for its response
    task automatic issue(input logic rw, input logic [1:0] sz, input logic u,
                         input logic [63:0] a, input logic [63:0] wd,
                         input logic [63:0] exp_rd, input logic exp_err, input int lat);
        wait_idle();
        DMEM_RW = rw;
        SIZE    = sz;
        UNS     = u;
        ADDR    = a;
        WDATA   = wd;
        REQ     = 1'b1;
        push(exp_rd, exp_err, cyc + lat);
        @(negedge CLK);
        REQ     = 1'b0;
        DMEM_RW = ~rw;
        SIZE    = ~sz;
        UNS     = ~u;
        ADDR    = 64'hFFFF_FFFF_DEAD_BEE7;
        WDATA   = '1;
        drain();
    endtask

    // Scoreboard monitor
    always @(negedge CLK) begin
        if (DONE) begin
            if (q_cyc.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: DONE=1 at cycle %0d, expected no response", cyc);
            end else begin
                check("done_cycle", 64'(cyc), 64'(q_cyc.pop_front()));
                check("rdata", RDATA, q_rd.pop_front());
                check("err", 64'(ERR), 64'(q_err.pop_front()));
            end
        end
    end

    int wr0;
    int s;

    initial begin
        repeat (3) @(negedge CLK);
        check("reset_rdata", RDATA, 64'd0);
        check("reset_done", 64'(DONE), 64'd0);
        check("reset_err", 64'(ERR), 64'd0);
        check("reset_busy", 64'(BUSY), 64'd0);
        check("reset_mem_addr", 64'(MEM_ADDR), 64'd0);
        check("reset_mem_wr", 64'(MEM_WR), 64'd0);
        check("reset_mem_din", 64'(MEM_DIN), 64'd0);
        init_mem = 1'b0;
        RESET = 1'b0;

        // Loads from word 0x100 = 0x80FF7F01
        issue(0, 2'b00, 0, 64'hABCD_0000_0000_0102, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 3);
        issue(0, 2'b00, 1, 64'h102, 0, 64'h0000_0000_0000_00FF, 0, 3);
        issue(0, 2'b00, 0, 64'h103, 0, 64'hFFFF_FFFF_FFFF_FF80, 0, 3);
        issue(0, 2'b01, 0, 64'h102, 0, 64'hFFFF_FFFF_FFFF_80FF, 0, 3);
        issue(0, 2'b01, 0, 64'h100, 0, 64'h0000_0000_0000_7F01, 0, 3);
        issue(0, 2'b00, 1, 64'h101, 0, 64'h0000_0000_0000_007F, 0, 3);
        issue(0, 2'b10, 0, 64'h100, 0, 64'hFFFF_FFFF_80FF_7F01, 0, 3);
        issue(0, 2'b10, 1, 64'h100, 0, 64'h0000_0000_80FF_7F01, 0, 3);

        // Double round-trip
        issue(1, 2'b11, 0, 64'h200, 64'h1122_3344_5566_7788, 64'h0000_0000_80FF_7F01, 0, 3);
        check("sd_lo_word", 64'(mem[10'h080]), 64'h5566_7788);
        check("sd_hi_word", 64'(mem[10'h081]), 64'h1122_3344);
        issue(0, 2'b11, 1, 64'h200, 0, 64'h1122_3344_5566_7788, 0, 5);

        // Misaligned double store
        wr0 = wr_cnt;
`ifdef DMEM_ALIGN_CHK_EN
        issue(1, 2'b11, 0, 64'h204, 64'h99AA_BBCC_DDEE_FF00, 64'h1122_3344_5566_7788, 1, 1);
        check("mis_sd_lo_kept", 64'(mem[10'h080]), 64'h5566_7788);
        check("mis_sd_hi_kept", 64'(mem[10'h081]), 64'h1122_3344);
        check("mis_sd_no_wr", 64'(wr_cnt - wr0), 64'd0);
`else
        issue(1, 2'b11, 0, 64'h204, 64'h99AA_BBCC_DDEE_FF00, 64'h1122_3344_5566_7788, 0, 3);
        check("mis_sd_lo_down", 64'(mem[10'h080]), 64'hDDEE_FF00);
        check("mis_sd_hi_down", 64'(mem[10'h081]), 64'h99AA_BBCC);
        check("mis_sd_wr", 64'(wr_cnt - wr0), 64'd2);
`endif

        // Sub-word stores via read-modify-write, and a plain word store
        wr0 = wr_cnt;
        issue(1, 2'b01, 0, 64'h302, 64'hFFFF_FFFF_FFFF_1234, 64'h1122_3344_5566_7788, 0, 4);
        check("sh_word", 64'(mem[10'h0C0]), 64'h1234_CCDD);
        check("sh_one_wr", 64'(wr_cnt - wr0), 64'd1);
        issue(1, 2'b00, 0, 64'h301, 64'hFFFF_FFFF_FFFF_FFA5, 64'h1122_3344_5566_7788, 0, 4);
        check("sb_word", 64'(mem[10'h0C0]), 64'h1234_A5DD);
        wr0 = wr_cnt;
        issue(1, 2'b10, 0, 64'h304, 64'h1234_5678_DEAD_BEEF, 64'h1122_3344_5566_7788, 0, 2);
        check("sw_word", 64'(mem[10'h0C1]), 64'hDEAD_BEEF);
        check("sw_one_wr", 64'(wr_cnt - wr0), 64'd1);

        // Misaligned word load
`ifdef DMEM_ALIGN_CHK_EN
        issue(0, 2'b10, 0, 64'h401, 0, 64'h1122_3344_5566_7788, 1, 1);
`else
        issue(0, 2'b10, 0, 64'h401, 0, 64'hFFFF_FFFF_CAFE_BABE, 0, 3);
`endif

        // REQ held high: one accept every fourth cycle, BUSY low only in IDLE
        wait_idle();
        DMEM_RW = 1'b0;
        SIZE    = 2'b10;
        UNS     = 1'b1;
        ADDR    = 64'h100;
        REQ     = 1'b1;
        s = cyc;
        for (int k = 0; k < 3; k++) push(64'h0000_0000_80FF_7F01, 0, s + 4 * k + 3);
        for (int k = 0; k < 12; k++) begin
            check("busy_window", 64'(BUSY), 64'((k % 4) != 0));
            @(negedge CLK);
        end
        REQ = 1'b0;
        check("busy_after_window", 64'(BUSY), 64'd0);
        drain();

        // Reset during RD_LO of a double load
        wait_idle();
        DMEM_RW = 1'b0;
        SIZE    = 2'b11;
        UNS     = 1'b0;
        ADDR    = 64'h200;
        REQ     = 1'b1;
        @(negedge CLK);
        REQ = 1'b0;
        check("rdlo_busy", 64'(BUSY), 64'd1);
        wr0 = wr_cnt;
        RESET = 1'b1;
        @(negedge CLK);
        check("rst_mid_busy", 64'(BUSY), 64'd0);
        check("rst_mid_rdata", RDATA, 64'd0);
        check("rst_mid_done", 64'(DONE), 64'd0);
        check("rst_mid_mem_addr", 64'(MEM_ADDR), 64'd0);
        check("rst_mid_mem_din", 64'(MEM_DIN), 64'd0);
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_mid_idle", 64'(BUSY), 64'd0);
        check("rst_mid_no_wr", 64'(wr_cnt - wr0), 64'd0);

        issue(0, 2'b10, 0, 64'h304, 0, 64'hFFFF_FFFF_DEAD_BEEF, 0, 3);

        repeat (3) @(negedge CLK);
        check("scoreboard_empty", 64'(q_cyc.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
